ras_stack: RTL and testbench

- Parametrised return address stack (RAS) for the fetch-stage branch predictor.
- Replaces the fixed 8-entry RAS sizing with configurable width, depth and overflow mode.
- Adds simultaneous push/pop (replace top), underflow/overflow flags, and pointer checkpoint/restore for misprediction recovery.
- Fetch pushes the link PC on calls and pops it on returns; the top entry is presented combinationally as the predicted return target.

---
 rtl/ras_stack_if.sv | 32 +++
 rtl/ras_stack.sv | 113 +++++++++++
 tb/tb_ras_stack.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ras_stack_if.sv
// Fetch-side bundle for the return address stack: call/return/restore requests
// and the predicted return target plus checkpointable pointer state.
interface ras_stack_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8
);
    localparam int PTR_W = $clog2(DEPTH);

    logic             push_i;
    logic [XLEN-1:0]  push_addr_i;
    logic             pop_i;
    logic             restore_i;
    logic [PTR_W-1:0] restore_ptr_i;
    logic [PTR_W:0]   restore_count_i;

    logic [XLEN-1:0]  top_o;
    logic             valid_o;
    logic [PTR_W-1:0] ptr_o;
    logic [PTR_W:0]   count_o;
    logic             overflow_o;
    logic             underflow_o;

    modport master (
        output push_i, push_addr_i, pop_i, restore_i, restore_ptr_i, restore_count_i,
        input  top_o, valid_o, ptr_o, count_o, overflow_o, underflow_o
    );

    modport slave (
        input  push_i, push_addr_i, pop_i, restore_i, restore_ptr_i, restore_count_i,
        output top_o, valid_o, ptr_o, count_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/ras_stack.sv
// Parametrised return address stack with replace-top, overflow/underflow pulses
// and pointer/count checkpoint restore for misprediction recovery.
module ras_stack #(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 8,
    parameter int WRAP_MODE = 1
) (
    input logic        clk,
    input logic        rst,
    ras_stack_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_RESTORE,
        OP_REPLACE,
        OP_PUSH,
        OP_POP
    } op_t;

    logic [XLEN-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] tos, tos_nxt, wr_idx;
    logic [PTR_W:0]   count, count_nxt;
    logic             wr_en;
    logic             ovf_q, ovf_nxt;
    logic             udf_q, udf_nxt;
    logic             full, empty;
    op_t              op;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // Push+pop on an empty stack has nothing to replace, so it decodes as a plain push.
    always_comb begin
        op = OP_IDLE;
        if (bus.restore_i)
            op = OP_RESTORE;
        else if (bus.push_i && bus.pop_i && !empty)
            op = OP_REPLACE;
        else if (bus.push_i)
            op = OP_PUSH;
        else if (bus.pop_i)
            op = OP_POP;
    end

    always_comb begin
        tos_nxt   = tos;
        count_nxt = count;
        wr_en     = 1'b0;
        wr_idx    = tos;
        ovf_nxt   = 1'b0;
        udf_nxt   = 1'b0;
        case (op)
            OP_RESTORE: begin
                tos_nxt   = bus.restore_ptr_i;
                count_nxt = bus.restore_count_i;
            end
            OP_REPLACE: begin
                wr_en = 1'b1;
            end
            OP_PUSH: begin
                if (!full) begin
                    tos_nxt   = tos + 1'b1;
                    count_nxt = count + 1'b1;
                    wr_en     = 1'b1;
                    wr_idx    = tos + 1'b1;
                end else begin
                    ovf_nxt = 1'b1;
                    if (WRAP_MODE != 0) begin
                        tos_nxt = tos + 1'b1;
                        wr_en   = 1'b1;
                        wr_idx  = tos + 1'b1;
                    end
                end
            end
            OP_POP: begin
                if (!empty) begin
                    tos_nxt   = tos - 1'b1;
                    count_nxt = count - 1'b1;
                end else begin
                    udf_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tos   <= '1;
            count <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
            mem   <= '{default: '0};
        end else begin
            tos   <= tos_nxt;
            count <= count_nxt;
            ovf_q <= ovf_nxt;
            udf_q <= udf_nxt;
            if (wr_en)
                mem[wr_idx] <= bus.push_addr_i;
        end
    end

    assign bus.top_o       = mem[tos];
    assign bus.valid_o     = !empty;
    assign bus.ptr_o       = tos;
    assign bus.count_o     = count;
    assign bus.overflow_o  = ovf_q;
    assign bus.underflow_o = udf_q;
endmodule

// File: tb/tb_ras_stack.sv
// Directed scoreboard bench for ras_stack: one circular (WRAP_MODE=1) and one
// drop-on-full (WRAP_MODE=0) instance, expectations queued per driven cycle.
module tb_ras_stack;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] top;
        logic [3:0]  cnt;
        logic [2:0]  ptr;
        logic        valid;
        logic        ovf;
        logic        udf;
    } exp_t;

    exp_t sb[$];

    ras_stack_if #(.XLEN(32), .DEPTH(8)) bw ();
    ras_stack_if #(.XLEN(32), .DEPTH(8)) bd ();

    ras_stack #(.XLEN(32), .DEPTH(8), .WRAP_MODE(1)) u_wrap (.clk(clk), .rst(rst), .bus(bw));
    ras_stack #(.XLEN(32), .DEPTH(8), .WRAP_MODE(0)) u_drop (.clk(clk), .rst(rst), .bus(bd));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cmp(string tag, string fld, logic [31:0] act, logic [31:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s.%s: got 0x%0h expected 0x%0h", tag, fld, act, exp);
        end
    endtask

    task automatic expect_st(string tag, int sel, logic [31:0] top, int cnt, int ptr,
                             bit ovf = 1'b0, bit udf = 1'b0);
        exp_t e;
        e.tag   = tag;
        e.sel   = sel;
        e.top   = top;
        e.cnt   = 4'(cnt);
        e.ptr   = 3'(ptr);
        e.valid = (cnt != 0);
        e.ovf   = ovf;
        e.udf   = udf;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t        e;
        logic [31:0] top;
        logic [3:0]  cnt;
        logic [2:0]  ptr;
        logic        valid, ovf, udf;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard: got empty queue expected an entry");
            return;
        end
        e = sb.pop_front();
        if (e.sel == 0) begin
            top = bw.top_o; cnt = bw.count_o; ptr = bw.ptr_o;
            valid = bw.valid_o; ovf = bw.overflow_o; udf = bw.underflow_o;
        end else begin
            top = bd.top_o; cnt = bd.count_o; ptr = bd.ptr_o;
            valid = bd.valid_o; ovf = bd.overflow_o; udf = bd.underflow_o;
        end
        cmp(e.tag, "top",   top,   e.top);
        cmp(e.tag, "count", 32'(cnt), 32'(e.cnt));
        cmp(e.tag, "ptr",   32'(ptr), 32'(e.ptr));
        cmp(e.tag, "valid", 32'(valid), 32'(e.valid));
        cmp(e.tag, "ovf",   32'(ovf), 32'(e.ovf));
        cmp(e.tag, "udf",   32'(udf), 32'(e.udf));
    endtask

    task automatic idle_all();
        bw.push_i = 1'b0; bw.pop_i = 1'b0; bw.push_addr_i = '0;
        bw.restore_i = 1'b0; bw.restore_ptr_i = '0; bw.restore_count_i = '0;
        bd.push_i = 1'b0; bd.pop_i = 1'b0; bd.push_addr_i = '0;
        bd.restore_i = 1'b0; bd.restore_ptr_i = '0; bd.restore_count_i = '0;
    endtask

    task automatic drive(int sel, bit push, bit pop, logic [31:0] addr,
                         bit rs = 1'b0, logic [2:0] rp = '0, logic [3:0] rc = '0);
        idle_all();
        if (sel == 0) begin
            bw.push_i = push; bw.pop_i = pop; bw.push_addr_i = addr;
            bw.restore_i = rs; bw.restore_ptr_i = rp; bw.restore_count_i = rc;
        end else begin
            bd.push_i = push; bd.pop_i = pop; bd.push_addr_i = addr;
            bd.restore_i = rs; bd.restore_ptr_i = rp; bd.restore_count_i = rc;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle_all();
        check_out();
    endtask

    initial begin
        logic [2:0]  save_ptr;
        logic [3:0]  save_cnt;
        int          p;
        rst = 1'b1;
        idle_all();
        #12;
        rst = 1'b0;
        #1;
        expect_st("reset_wrap", 0, 32'h0, 0, 7);
        expect_st("reset_drop", 1, 32'h0, 0, 7);
        check_out();
        check_out();

        // Basic LIFO on the circular instance
        drive(0, 1, 0, 32'h100); expect_st("lifo_push1", 0, 32'h100, 1, 0); tick();
        drive(0, 1, 0, 32'h200); expect_st("lifo_push2", 0, 32'h200, 2, 1); tick();
        drive(0, 1, 0, 32'h300); expect_st("lifo_push3", 0, 32'h300, 3, 2); tick();
        drive(0, 0, 1, 32'h0);   expect_st("lifo_pop1",  0, 32'h200, 2, 1); tick();
        drive(0, 0, 1, 32'h0);   expect_st("lifo_pop2",  0, 32'h100, 1, 0); tick();
        drive(0, 0, 1, 32'h0);   expect_st("lifo_pop3",  0, 32'h0,   0, 7); tick();

        // Overflow, circular: 9th push overwrites the oldest entry
        for (int i = 1; i <= 8; i++) begin
            drive(0, 1, 0, 32'(16 * i));
            expect_st("wrap_fill", 0, 32'(16 * i), i, i - 1);
            tick();
        end
        drive(0, 1, 0, 32'h90); expect_st("wrap_ovf", 0, 32'h90, 8, 0, 1'b1); tick();
        for (int k = 1; k <= 8; k++) begin
            p = (8 - k) % 8;
            drive(0, 0, 1, 32'h0);
            expect_st("wrap_drain", 0, (p == 0) ? 32'h90 : 32'(16 * (p + 1)), 8 - k, p);
            tick();
        end

        // Overflow, drop mode: 9th push discarded
        for (int i = 1; i <= 8; i++) begin
            drive(1, 1, 0, 32'(16 * i));
            expect_st("drop_fill", 1, 32'(16 * i), i, i - 1);
            tick();
        end
        drive(1, 1, 0, 32'h90); expect_st("drop_ovf", 1, 32'h80, 8, 7, 1'b1); tick();
        for (int k = 1; k <= 8; k++) begin
            p = (15 - k) % 8;
            drive(1, 0, 1, 32'h0);
            expect_st("drop_drain", 1, 32'(16 * (p + 1)), 8 - k, p);
            tick();
        end

        // Underflow pulse on empty pop
        drive(1, 0, 1, 32'h0);  expect_st("udf_pop",   1, 32'h80, 0, 7, 1'b0, 1'b1); tick();
        drive(1, 0, 0, 32'h0);  expect_st("udf_clear", 1, 32'h80, 0, 7); tick();
        drive(1, 1, 0, 32'h55); expect_st("udf_push",  1, 32'h55, 1, 0); tick();

        // Push+pop replaces top; on empty it is a plain push
        drive(0, 1, 0, 32'h100); expect_st("rep_push1", 0, 32'h100, 1, 1); tick();
        drive(0, 1, 0, 32'h200); expect_st("rep_push2", 0, 32'h200, 2, 2); tick();
        drive(0, 1, 1, 32'h444); expect_st("rep_both",  0, 32'h444, 2, 2); tick();
        drive(0, 0, 1, 32'h0);   expect_st("rep_pop1",  0, 32'h100, 1, 1); tick();
        drive(0, 0, 1, 32'h0);   expect_st("rep_pop2",  0, 32'h90,  0, 0); tick();
        drive(0, 1, 1, 32'h777); expect_st("rep_empty", 0, 32'h777, 1, 1); tick();

        // Checkpoint, speculative changes, then restore with a competing push
        drive(0, 1, 0, 32'hA0); expect_st("ckpt_pushA", 0, 32'hA0, 2, 2); tick();
        drive(0, 1, 0, 32'hB0); expect_st("ckpt_pushB", 0, 32'hB0, 3, 3); tick();
        save_ptr = bw.ptr_o;
        save_cnt = bw.count_o;
        drive(0, 0, 1, 32'h0);  expect_st("spec_pop1", 0, 32'hA0,  2, 2); tick();
        drive(0, 0, 1, 32'h0);  expect_st("spec_pop2", 0, 32'h777, 1, 1); tick();
        drive(0, 1, 0, 32'hC0); expect_st("spec_push", 0, 32'hC0,  2, 2); tick();
        drive(0, 1, 0, 32'hDD, 1'b1, save_ptr, save_cnt);
        expect_st("restore", 0, 32'hB0, 3, 3); tick();

        // Asynchronous reset between clock edges
        drive(0, 1, 0, 32'hEE); expect_st("pre_rst", 0, 32'hEE, 4, 4); tick();
        #2;
        rst = 1'b1;
        #1;
        expect_st("arst_wrap", 0, 32'h0, 0, 7);
        expect_st("arst_drop", 1, 32'h0, 0, 7);
        check_out();
        check_out();
        @(posedge clk);
        #1;
        expect_st("arst_hold", 0, 32'h0, 0, 7);
        check_out();
        #2;
        rst = 1'b0;
        drive(0, 1, 0, 32'h123); expect_st("post_rst", 0, 32'h123, 1, 0); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
